r_read_arbiter: RTL and testbench

Read-side arbiter for the asynchronous FIFO, living entirely in the read clock domain. It shares the FIFO's single read port among NUM_REQ consumers using round-robin bursts. It drives the FIFO read enable and stalls on empty. It tags every returned word with the owning consumer so downstream logic can route the read data.

---
 rtl/r_read_arbiter_if.sv | 26 ++
 rtl/r_read_arbiter.sv | 134 +++++++++++++
 tb/tb_r_read_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/r_read_arbiter_if.sv
// Read-port arbitration bundle between the consumers/FIFO (master) and the
// read-side arbiter (slave).
interface r_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int BURST_W = 3
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*BURST_W-1:0] burst_len;
  logic                       r_empty;
  logic                       r_en;
  logic [NUM_REQ-1:0]         grant;
  logic                       r_data_valid;
  logic [NUM_REQ-1:0]         r_data_owner;
  logic                       burst_done;
  logic                       busy;

  modport master (
    output req, burst_len, r_empty,
    input  r_en, grant, r_data_valid, r_data_owner, burst_done, busy
  );

  modport slave (
    input  req, burst_len, r_empty,
    output r_en, grant, r_data_valid, r_data_owner, burst_done, busy
  );
endinterface

// File: rtl/r_read_arbiter.sv
// Round-robin burst arbiter for the async FIFO read port; tags each returned
// word with its owning consumer after READ_LATENCY cycles.
module r_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BURST_W      = 3,
  parameter int READ_LATENCY = 1
) (
  input logic          r_clk,
  input logic          rrst_n,
  r_read_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = BURST_W + 1;
  localparam int DRN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MAX_BURST = {1'b1, {BURST_W{1'b0}}};
  localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   prio_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [DRN_W-1:0]   drain_reg;
  logic               done_reg;

  logic               vld_pipe [READ_LATENCY];
  logic [NUM_REQ-1:0] own_pipe [READ_LATENCY];

  logic [BURST_W-1:0] len_arr [NUM_REQ];
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               owner_req;
  logic               rd_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_len
      assign len_arr[gi] = bus.burst_len[gi*BURST_W +: BURST_W];
    end
  endgenerate

  // First requester at or after prio, wrapping around.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] j_idx;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    j_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(prio_reg) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IDX_W'(j);
      if (!win_found && bus.req[j_idx]) begin
        win_found = 1'b1;
        win_idx   = j_idx;
      end
    end
  end

  assign owner_req = bus.req[owner_reg];
  assign rd_fire   = (state_reg == READ) && !bus.r_empty && owner_req;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      prio_reg  <= '0;
      count_reg <= '0;
      drain_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            grant_reg <= NUM_REQ'(1) << win_idx;
            owner_reg <= win_idx;
            count_reg <= (len_arr[win_idx] == '0) ? MAX_BURST : {1'b0, len_arr[win_idx]};
            state_reg <= READ;
          end
        end
        READ: begin
          // Release takes precedence: no read is issued once req drops.
          if (!owner_req || (rd_fire && count_reg == CNT_W'(1))) begin
            state_reg <= DRAIN;
            drain_reg <= '0;
            done_reg  <= (READ_LATENCY == 1);
          end
          if (rd_fire) begin
            count_reg <= count_reg - 1'b1;
          end
        end
        DRAIN: begin
          if (drain_reg == DRN_LAST) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            prio_reg  <= (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
          end else begin
            drain_reg <= drain_reg + 1'b1;
            done_reg  <= (drain_reg + 1'b1 == DRN_LAST);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        vld_pipe[s] <= 1'b0;
        own_pipe[s] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_fire;
      own_pipe[0] <= rd_fire ? grant_reg : '0;
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        own_pipe[s] <= own_pipe[s-1];
      end
    end
  end

  assign bus.r_en         = rd_fire;
  assign bus.grant        = grant_reg;
  assign bus.r_data_valid = vld_pipe[READ_LATENCY-1];
  assign bus.r_data_owner = own_pipe[READ_LATENCY-1];
  assign bus.burst_done   = done_reg;
  assign bus.busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_r_read_arbiter.sv
// Drives a READ_LATENCY=1 and a READ_LATENCY=2 arbiter with shared requests
// and checks every output each cycle against a transaction-level model.
module tb_r_read_arbiter;
  localparam int N  = 4;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 clk = ~clk;

  r_read_arbiter_if #(.NUM_REQ(N), .BURST_W(BW)) bus0 ();
  r_read_arbiter_if #(.NUM_REQ(N), .BURST_W(BW)) bus1 ();

  r_read_arbiter #(.NUM_REQ(N), .BURST_W(BW), .READ_LATENCY(1)) u_dut0 (
    .r_clk(clk), .rrst_n(rrst_n), .bus(bus0));
  r_read_arbiter #(.NUM_REQ(N), .BURST_W(BW), .READ_LATENCY(2)) u_dut1 (
    .r_clk(clk), .rrst_n(rrst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rl [2] = '{1, 2};

  logic [N-1:0]    req = '0;
  logic [N*BW-1:0] blen = '0;
  int              fifo_cnt [2] = '{0, 0};
  logic            emp [2] = '{1'b1, 1'b1};

  assign bus0.req = req;        assign bus1.req = req;
  assign bus0.burst_len = blen; assign bus1.burst_len = blen;
  assign bus0.r_empty = emp[0]; assign bus1.r_empty = emp[1];

  logic o_ren [2], o_vld [2], o_done [2], o_busy [2];
  logic [N-1:0] o_grant [2], o_owner [2];
  assign o_ren[0] = bus0.r_en;           assign o_ren[1] = bus1.r_en;
  assign o_vld[0] = bus0.r_data_valid;   assign o_vld[1] = bus1.r_data_valid;
  assign o_done[0] = bus0.burst_done;    assign o_done[1] = bus1.burst_done;
  assign o_busy[0] = bus0.busy;          assign o_busy[1] = bus1.busy;
  assign o_grant[0] = bus0.grant;        assign o_grant[1] = bus1.grant;
  assign o_owner[0] = bus0.r_data_owner; assign o_owner[1] = bus1.r_data_owner;

  // Model: owner index (-1 when idle), words left, drain cycles left, and a
  // ring of words scheduled to appear at a given cycle.
  int           m_own [2], m_left [2], m_drain [2], m_prio [2];
  logic         m_vld_at [2][8];
  logic [N-1:0] m_oat [2][8];

  int           obs_ren [2] = '{0, 0};
  int           obs_vld [2] = '{0, 0};
  int           obs_done [2] = '{0, 0};
  logic [N-1:0] prev_grant [2] = '{'0, '0};
  logic [N-1:0] gq [$];
  int           gcyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_left[k] = 0; m_drain[k] = 0; m_prio[k] = 0;
      for (int s = 0; s < 8; s++) begin
        m_vld_at[k][s] = 1'b0;
        m_oat[k][s] = '0;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ren%0d", tag, k), o_ren[k], 0);
      chk($sformatf("%s_grant%0d", tag, k), o_grant[k], 0);
      chk($sformatf("%s_vld%0d", tag, k), o_vld[k], 0);
      chk($sformatf("%s_owner%0d", tag, k), o_owner[k], 0);
      chk($sformatf("%s_done%0d", tag, k), o_done[k], 0);
      chk($sformatf("%s_busy%0d", tag, k), o_busy[k], 0);
    end
  endtask

  task automatic set_len(input int i, input int v);
    blen[i*BW +: BW] = BW'(v);
  endtask

  task automatic set_fifo(input int k, input int n);
    fifo_cnt[k] = n;
    emp[k] = (fifo_cnt[k] == 0);
  endtask

  task automatic add_words(input int k, input int n);
    set_fifo(k, fifo_cnt[k] + n);
  endtask

  task automatic tick();
    logic e_ren, e_vld, e_done, e_busy;
    logic [N-1:0] e_grant, e_owner;
    int slot;
    @(negedge clk);
    slot = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      e_grant = (m_own[k] >= 0) ? (N'(1) << m_own[k]) : '0;
      e_ren   = (m_own[k] >= 0) && (m_drain[k] == 0) && !emp[k] && req[m_own[k]];
      e_done  = (m_own[k] >= 0) && (m_drain[k] == 1);
      e_busy  = (m_own[k] >= 0);
      e_vld   = m_vld_at[k][slot];
      e_owner = m_oat[k][slot];
      chk($sformatf("ren%0d@%0d", k, cyc), o_ren[k], e_ren);
      chk($sformatf("grant%0d@%0d", k, cyc), o_grant[k], e_grant);
      chk($sformatf("vld%0d@%0d", k, cyc), o_vld[k], e_vld);
      chk($sformatf("owner%0d@%0d", k, cyc), o_owner[k], e_owner);
      chk($sformatf("done%0d@%0d", k, cyc), o_done[k], e_done);
      chk($sformatf("busy%0d@%0d", k, cyc), o_busy[k], e_busy);
      if (o_ren[k] === 1'b1) obs_ren[k]++;
      if (o_vld[k] === 1'b1) obs_vld[k]++;
      if (o_done[k] === 1'b1) obs_done[k]++;
      if (k == 0 && prev_grant[0] == '0 && o_grant[0] != '0) begin
        gq.push_back(o_grant[0]);
        gcyc.push_back(cyc);
      end
      prev_grant[k] = o_grant[k];

      m_vld_at[k][slot] = 1'b0;
      m_oat[k][slot] = '0;
      if (e_ren) fifo_cnt[k]--;
      if (m_own[k] < 0) begin
        for (int s = 0; s < N; s++) begin
          int c;
          c = (m_prio[k] + s) % N;
          if (m_own[k] < 0 && req[c]) begin
            m_own[k] = c;
            m_left[k] = int'(blen[c*BW +: BW]);
            if (m_left[k] == 0) m_left[k] = 1 << BW;
            m_drain[k] = 0;
          end
        end
      end else if (m_drain[k] == 0) begin
        if (!req[m_own[k]]) begin
          m_drain[k] = rl[k];
        end else if (e_ren) begin
          m_left[k]--;
          m_vld_at[k][(cyc + rl[k]) % 8] = 1'b1;
          m_oat[k][(cyc + rl[k]) % 8] = e_grant;
          if (m_left[k] == 0) m_drain[k] = rl[k];
        end
      end else begin
        m_drain[k]--;
        if (m_drain[k] == 0) begin
          m_prio[k] = (m_own[k] + 1) % N;
          m_own[k] = -1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) emp[k] = (fifo_cnt[k] == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_done(input int k, input int bound, input string tag);
    int start, n;
    start = obs_done[k];
    n = 0;
    while (obs_done[k] == start && n < bound) begin
      tick();
      n++;
    end
    chk(tag, obs_done[k] - start, 1);
  endtask

  task automatic pulse_reset(input string tag);
    #1 rrst_n = 1'b0;
    #1 chk_all_zero(tag);
    reset_model();
    #1 rrst_n = 1'b1;
  endtask

  initial begin
    int v0, r0, v1, r1, n;
    logic [N-1:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_model();
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rrst_n = 1'b1;

    // Single burst: consumer 2, three words.
    set_fifo(0, 8); set_fifo(1, 8);
    set_len(2, 3);
    req = 4'b0100;
    v0 = obs_vld[0]; r0 = obs_ren[0];
    tick();
    chk("single_grant", o_grant[0], 4'b0100);
    run_until_done(0, 20, "single_done");
    req = '0;
    chk("single_ren_cnt", obs_ren[0] - r0, 3);
    chk("single_vld_cnt", obs_vld[0] - v0, 3);
    tick();
    chk("single_grant_drop", o_grant[0], 0);
    ticks(4);

    // Round-robin with one-word bursts from a never-empty FIFO.
    pulse_reset("rr_reset");
    set_fifo(0, 60); set_fifo(1, 60);
    for (int i = 0; i < N; i++) set_len(i, 1);
    gq.delete(); gcyc.delete();
    req = 4'b1111;
    n = 0;
    while (gq.size() < 5 && n < 40) begin
      tick();
      n++;
    end
    req = '0;
    chk("rr_grants", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk($sformatf("rr_order%0d", i), gq[i], rr_exp[i]);
    for (int i = 1; i < gq.size(); i++)
      chk($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 3);
    ticks(8);

    // Empty stall: four-word burst with only two words present.
    set_fifo(0, 2); set_fifo(1, 2);
    set_len(0, 4);
    req = 4'b0001;
    v0 = obs_vld[0]; r0 = obs_ren[0];
    ticks(10);
    chk("stall_reads", obs_ren[0] - r0, 2);
    chk("stall_ren_low", o_ren[0], 0);
    chk("stall_busy", o_busy[0], 1);
    add_words(0, 2); add_words(1, 2);
    run_until_done(0, 20, "stall_done");
    chk("stall_vld_cnt", obs_vld[0] - v0, 4);
    req = '0;
    ticks(4);

    // burst_len=0 means a full 2^BW-word burst.
    set_fifo(0, 20); set_fifo(1, 20);
    set_len(1, 0);
    req = 4'b0010;
    v0 = obs_vld[0];
    run_until_done(0, 30, "len0_done");
    chk("len0_vld_cnt", obs_vld[0] - v0, 8);
    req = '0;
    ticks(4);

    // Early release by consumer 3 after two reads.
    set_len(3, 5);
    req = 4'b1000;
    v0 = obs_vld[0]; r0 = obs_ren[0];
    n = 0;
    while (obs_ren[0] - r0 < 2 && n < 20) begin
      tick();
      n++;
    end
    req = '0;
    run_until_done(0, 10, "early_done");
    chk("early_vld_cnt", obs_vld[0] - v0, 2);
    ticks(3);
    gq.delete(); gcyc.delete();
    req = 4'b1111;
    n = 0;
    while (gq.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    chk("early_prio_wrap", (gq.size() > 0) ? gq[0] : 'x, 4'b0001);
    req = '0;
    ticks(12);

    // Latency-2 instance reset with words in flight.
    set_fifo(0, 20); set_fifo(1, 20);
    set_len(2, 6);
    req = 4'b0100;
    r1 = obs_ren[1];
    n = 0;
    while (obs_ren[1] - r1 < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("rl2_reads", obs_ren[1] - r1, 3);
    pulse_reset("midburst_reset");
    req = '0;
    v1 = obs_vld[1];
    ticks(3);
    chk("rl2_no_vld_after_reset", obs_vld[1] - v1, 0);
    req = 4'b1010;
    tick();
    chk("rl2_regrant1", o_grant[1], 4'b0010);
    chk("rl2_regrant0", o_grant[0], 4'b0010);
    req = '0;
    ticks(12);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      if ($urandom_range(0, 7) == 0) blen = (N*BW)'($urandom);
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 2) == 0) add_words(k, int'($urandom_range(0, 3)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
